// File: rtl/crc_generator_if.sv
// rtl/crc_generator_if.sv - data word / CRC result bundle for crc_generator
interface crc_generator_if #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned POLYNOMIAL_BITS = 1
);
  logic [DATA_WIDTH-1:0]      data_in;
  logic [POLYNOMIAL_BITS-1:0] crc_val;

  // Producer of data words, consumer of the CRC.
  modport master (
    output data_in,
    input  crc_val
  );

  // The CRC generator itself.
  modport slave (
    input  data_in,
    output crc_val
  );
endinterface

// File: rtl/crc_generator.sv
// rtl/crc_generator.sv - single-word parallel CRC; CRC_GENERATOR_OUT_REG_EN selects a registered output
module crc_generator #(
  parameter int unsigned                DATA_WIDTH      = 8,
  parameter int unsigned                POLYNOMIAL_BITS = 1,
  parameter logic [POLYNOMIAL_BITS-1:0] POLYNOMIAL      = POLYNOMIAL_BITS'(1),
  parameter logic [POLYNOMIAL_BITS-1:0] INIT            = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  crc_generator_if.slave       bus
);

  logic [DATA_WIDTH-1:0]      data;
  logic [POLYNOMIAL_BITS-1:0] crc_d;
  logic                       fb;

  assign data = bus.data_in;

  // Unrolled MSB-first LFSR: every word starts from INIT, so nothing carries between words.
  always_comb begin
    crc_d = INIT;
    fb    = 1'b0;
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      fb    = crc_d[POLYNOMIAL_BITS-1] ^ data[i];
      crc_d = crc_d << 1;
      if (fb) begin
        crc_d = crc_d ^ POLYNOMIAL;
      end
    end
  end

`ifdef CRC_GENERATOR_OUT_REG_EN
  logic [POLYNOMIAL_BITS-1:0] crc_val_q;

  // Output register; reset clears it at once and drops any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_val_q <= '0;
    end else begin
      crc_val_q <= crc_d;
    end
  end

  assign bus.crc_val = crc_val_q;
`else
  // Combinational build: clk and rst_n stay on the port list but drive nothing.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign bus.crc_val = crc_d;
`endif

endmodule

// File: tb/tb_crc_generator.sv
// tb/tb_crc_generator.sv - scoreboard bench for crc_generator (both output modes)
module tb_crc_generator;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  crc_generator_if #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(1))  if_par ();
  crc_generator_if #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(8))  if_c8  ();
  crc_generator_if #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(16)) if_c16 ();
  crc_generator_if #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(8))  if_a   ();
  crc_generator_if #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(8))  if_b   ();

  crc_generator u_par (.clk(clk), .rst_n(rst_n), .bus(if_par));

  crc_generator #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(8), .POLYNOMIAL(8'h07), .INIT(8'h00))
    u_c8 (.clk(clk), .rst_n(rst_n), .bus(if_c8));

  crc_generator #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(16), .POLYNOMIAL(16'h1021), .INIT(16'h0000))
    u_c16 (.clk(clk), .rst_n(rst_n), .bus(if_c16));

  crc_generator #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(8), .POLYNOMIAL(8'h07), .INIT(8'h00))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

  crc_generator #(.DATA_WIDTH(8), .POLYNOMIAL_BITS(8), .POLYNOMIAL(8'h07), .INIT(8'h00))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return 32'(if_par.crc_val);
      1:       return 32'(if_c8.crc_val);
      2:       return 32'(if_c16.crc_val);
      3:       return 32'(if_a.crc_val);
      default: return 32'(if_b.crc_val);
    endcase
  endfunction

  function automatic logic [7:0] crc8_model(input logic [7:0] d);
    logic [7:0] c = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = (c << 1) ^ 8'h07;
      else             c = c << 1;
    end
    return c;
  endfunction

  task automatic push(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Inputs change on the falling edge; results are expected one rising edge later.
  task automatic drive(input int sel, input logic [7:0] d, input logic [31:0] exp, input string name);
    @(negedge clk);
    case (sel)
      0:       if_par.data_in = d;
      1:       if_c8.data_in  = d;
      default: if_c16.data_in = d;
    endcase
    push(name, sel, exp);
  endtask

  // Monitor: after each rising edge every pending expectation is due.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, actual(e.sel), e.val);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] db;
    int         k;
    int         guard;

    if_par.data_in = 8'h00;
    if_c8.data_in  = 8'h01;
    if_c16.data_in = 8'h00;
    if_a.data_in   = 8'h00;
    if_b.data_in   = 8'h00;
    #2;
`ifdef CRC_GENERATOR_OUT_REG_EN
    check("reset_c8", 32'(if_c8.crc_val), 32'h00);
    check("reset_par", 32'(if_par.crc_val), 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold_c8", 32'(if_c8.crc_val), 32'h00);
`else
    check("reset_comb_c8", 32'(if_c8.crc_val), 32'h07);
    check("reset_comb_par", 32'(if_par.crc_val), 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 8'hA5, 32'h0,    "par_a5");
    drive(0, 8'h01, 32'h1,    "par_01");
    drive(0, 8'hFF, 32'h0,    "par_ff");
    drive(0, 8'h07, 32'h1,    "par_07");
    drive(1, 8'h01, 32'h07,   "c8_01");
    drive(1, 8'h80, 32'h89,   "c8_80");
    drive(1, 8'h00, 32'h00,   "c8_00");
    drive(1, 8'hFF, 32'hF3,   "c8_ff");
    drive(1, 8'h02, 32'h0E,   "c8_02");
    drive(2, 8'h01, 32'h1021, "c16_01");
    drive(2, 8'h80, 32'h9188, "c16_80");
    drive(2, 8'h02, 32'h2042, "c16_02");
    drive(2, 8'h00, 32'h0000, "c16_00");

    // Twin instances: equal inputs on even steps, one flipped bit on odd steps.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      d  = 8'($urandom);
      k  = int'($urandom_range(0, 7));
      db = (n % 2 == 1) ? (d ^ (8'(1) << k)) : d;
      if_a.data_in = d;
      if_b.data_in = db;
      push("twin_a", 3, 32'(crc8_model(d)));
      push("twin_b", 4, 32'(crc8_model(db)));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) check("drain", 32'(exp_q.size()), 32'h0);

`ifdef CRC_GENERATOR_OUT_REG_EN
    @(negedge clk);
    rst_n = 1'b0;
    if_c8.data_in = 8'h01;
    #1;
    check("reg_rst_low", 32'(if_c8.crc_val), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reg_rst_noedge", 32'(if_c8.crc_val), 32'h00);
    @(posedge clk);
    #1;
    check("reg_first_edge", 32'(if_c8.crc_val), 32'h07);
    @(negedge clk);
    if_c8.data_in = 8'h80;
    @(posedge clk);
    #1;
    check("reg_latency", 32'(if_c8.crc_val), 32'h89);
    #2;
    rst_n = 1'b0;
    #1;
    check("reg_async_clear", 32'(if_c8.crc_val), 32'h00);
    @(negedge clk);
    if_c8.data_in = 8'hFF;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reg_post_reset", 32'(if_c8.crc_val), 32'hF3);
`else
    @(negedge clk);
    clk_en = 1'b0;
    rst_n  = 1'b0;
    if_c8.data_in = 8'h01;
    #1;
    check("comb_noclk_01", 32'(if_c8.crc_val), 32'h07);
    if_c8.data_in = 8'h80;
    #1;
    check("comb_noclk_80", 32'(if_c8.crc_val), 32'h89);
    rst_n = 1'b1;
    if_c8.data_in = 8'hFF;
    #1;
    check("comb_noclk_ff", 32'(if_c8.crc_val), 32'hF3);
    rst_n = 1'b0;
    if_par.data_in = 8'h01;
    #1;
    check("comb_noclk_par", 32'(if_par.crc_val), 32'h1);
    rst_n  = 1'b1;
    clk_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
